// File: rtl/uart_rx_top.sv
// uart_rx_top: oversampling UART receiver, 8 data bits, optional parity, one stop bit.
module uart_rx_top #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PAR_TYP,
    input  logic                  PAR_EN,
    input  logic [5:0]            Prescale,
    input  logic                  RX_IN,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam int BW = $clog2(DATA_WIDTH);
    state_t state, next;
    logic [5:0] p_lat, edge_cnt;
    logic par_en, par_typ, parity_err;
    logic [BW-1:0] bit_cnt;
    logic [1:0] smp;
    logic [DATA_WIDTH-1:0] shift;
    logic mid, last, bit_val, exp_par, start_det;
    assign mid       = edge_cnt == (p_lat >> 1) + 6'd1;
    assign last      = edge_cnt == p_lat - 6'd1;
    assign bit_val   = (smp[0] & smp[1]) | (smp[0] & RX_IN) | (smp[1] & RX_IN);
    assign exp_par   = par_typ ? ~^shift : ^shift;
    assign start_det = state == IDLE && !RX_IN;
    always_ff @(posedge clk)
        state <= rst ? IDLE : next;
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = RX_IN ? IDLE : START;
            START:   next = (mid && bit_val) ? IDLE : (last ? DATA : START);
            DATA:    next = (last && bit_cnt == BW'(DATA_WIDTH - 1)) ? (par_en ? PARITY : STOP) : DATA;
            PARITY:  next = last ? STOP : PARITY;
            STOP:    next = mid ? IDLE : STOP;
            default: next = IDLE;
        endcase
    end
    // The line may go low again during the tail of the stop period, so STOP exits at its decision point.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_lat      <= '0;
            edge_cnt   <= '0;
            par_en     <= 1'b0;
            par_typ    <= 1'b0;
            parity_err <= 1'b0;
            bit_cnt    <= '0;
            smp        <= '0;
            shift      <= '0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
        end else begin
            edge_cnt <= state == IDLE ? {5'b0, !RX_IN} : (last ? 6'd0 : edge_cnt + 6'd1);
            if (edge_cnt == (p_lat >> 1) - 6'd1) smp[0] <= RX_IN;
            if (edge_cnt == (p_lat >> 1)) smp[1] <= RX_IN;
            if (start_det) begin
                p_lat      <= Prescale;
                par_en     <= PAR_EN;
                par_typ    <= PAR_TYP;
                parity_err <= 1'b0;
                bit_cnt    <= '0;
                data_valid <= 1'b0;
            end
            if (state == DATA && mid) shift[bit_cnt] <= bit_val;
            if (state == DATA && last) bit_cnt <= bit_cnt + 1'b1;
            if (state == PARITY && mid) parity_err <= bit_val != exp_par;
            if (state == STOP && mid && bit_val && !parity_err) begin
                P_DATA     <= shift;
                data_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_top.sv
// tb_uart_rx_top: directed frames with a queue scoreboard checked on each data_valid rise.
module tb_uart_rx_top;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic PAR_TYP = 1'b0;
    logic PAR_EN = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic RX_IN = 1'b1;
    logic [7:0] P_DATA;
    logic data_valid;
    int total = 0;
    int passed = 0;
    logic [7:0] exp_q[$];
    logic dv_q = 1'b0;

    uart_rx_top dut (
        .clk(clk), .rst(rst), .PAR_TYP(PAR_TYP), .PAR_EN(PAR_EN),
        .Prescale(Prescale), .RX_IN(RX_IN), .P_DATA(P_DATA), .data_valid(data_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (data_valid && !dv_q) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_valid: got P_DATA=%h expected no byte", P_DATA);
            end else check("rx_byte", P_DATA, exp_q.pop_front());
        end
        dv_q = data_valid;
    end

    task automatic send_bit(input logic b, input int p);
        RX_IN = b;
        repeat (p) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt, input logic pb,
                              input logic sb, input int p, input bit chk_drop);
        PAR_EN = pe;
        PAR_TYP = pt;
        Prescale = 6'(p);
        RX_IN = 1'b0;
        @(negedge clk);
        if (chk_drop) check("valid_drop_at_start", {7'b0, data_valid}, 8'h00);
        repeat (p - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) send_bit(d[i], p);
        if (pe) send_bit(pb, p);
        send_bit(sb, p);
    endtask

    task automatic check_idle(input string name, input logic [7:0] pd);
        check({name, "_valid"}, {7'b0, data_valid}, 8'h00);
        check({name, "_data"}, P_DATA, pd);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset", 8'h00);

        exp_q.push_back(8'h45);
        send_frame(8'h45, 0, 0, 0, 1, 8, 0);
        send_bit(1, 4);
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1, 1, 1, 1, 8, 0);
        send_bit(1, 4);
        exp_q.push_back(8'hA8);
        send_frame(8'hA8, 1, 0, 1, 1, 8, 0);
        send_bit(1, 4);

        send_frame(8'hA8, 1, 0, 0, 1, 8, 0);
        send_bit(1, 12);
        check_idle("bad_parity", 8'hA8);
        send_frame(8'h3C, 0, 0, 0, 0, 8, 0);
        send_bit(1, 12);
        check_idle("bad_stop", 8'hA8);
        send_bit(0, 2);
        send_bit(1, 12);
        check_idle("glitch", 8'hA8);

        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 0, 0, 0, 1, 16, 0);
        send_bit(1, 1);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 0, 0, 0, 1, 16, 1);
        send_bit(1, 6);

        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 0, 0, 0, 1, 32, 0);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 0, 0, 0, 1, 32, 1);
        send_bit(1, 6);

        Prescale = 6'd8;
        PAR_EN = 1'b0;
        send_bit(0, 8);
        send_bit(1, 8);
        send_bit(1, 8);
        send_bit(0, 4);
        rst = 1'b1;
        RX_IN = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("mid_reset", 8'h00);
        send_bit(1, 10);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1, 0, 0, 1, 8, 0);
        send_bit(1, 10);

        check("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_rx_top.md
Name: uart_rx_top

Overview:
Asynchronous UART serial receiver. It oversamples the RX_IN line at the system clock, using a configurable Prescale (clocks per bit). It deserialises one start bit, 8 data bits (LSB first), an optional parity bit and one stop bit. It presents the byte on P_DATA with a data_valid flag. It sits at the RX edge of a UART link and feeds a byte-wide consumer.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (only 8 is required).

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
PAR_TYP  input  1  parity type: 0 = even (parity bit = XOR of data), 1 = odd (parity bit = XNOR of data).
PAR_EN  input  1  1 = frame carries a parity bit between data and stop.
Prescale  input  6  clock cycles per bit; supported values are even values 6..32 (8, 16, 32 are mandatory).
RX_IN  input  1  serial line; idles high.
P_DATA  output  8  last correctly received byte.
data_valid  output  1  high while P_DATA holds a freshly received, error-free byte.

Behaviour:
- Reset, synchronous and active-high: state=IDLE, counters=0, P_DATA=0, data_valid=0. Reset mid-frame aborts the frame and returns to IDLE.
- Config latching: PAR_EN, PAR_TYP and Prescale are captured on the IDLE→START transition and held for the whole frame.
- Edge counter edge_cnt runs 0..Prescale-1 within each bit period. Bit-period 0 is the clock on which RX_IN=0 is first seen in IDLE.
- Sampling: each bit is sampled at edge_cnt = P/2-1, P/2 and P/2+1, where P is the latched Prescale. The bit value is the majority of the 3 samples, decided at P/2+1.
- State machine: IDLE, START, DATA, PARITY, STOP.
- IDLE: wait for RX_IN=0, then go to START with edge_cnt=1. Clear data_valid in the same cycle.
- START: if the sampled start bit is 1 (glitch), return to IDLE with no output change. Otherwise go to DATA at edge_cnt=P-1.
- DATA: shift the sampled bit into bit position bit_cnt (LSB first). After 8 bits, go to PARITY if PAR_EN=1, else STOP, at the end of the 8th bit period.
- PARITY: compare the sampled bit with the expected parity of the 8 data bits. Record parity_err on mismatch. Go to STOP at the end of the bit period.
- STOP: at the P/2+1 decision, if stop=1 and no parity_err: load P_DATA with the shift register and set data_valid=1 on the next clock edge. Then return to IDLE immediately, ready to accept a start bit during the remainder of the stop period.
- On stop=0 or parity error: return to IDLE. P_DATA keeps its previous value and data_valid stays 0. The error is not externally signalled.
- data_valid is held high, with P_DATA stable, until the next start bit is detected or reset.
- Back-to-back frames, including a start bit immediately after the stop period, are received without loss.
- RX_IN is used directly. Upstream must supply a signal already synchronous to clk.

Test Plan:
- Reset check: rst=1 for 1+ cycles with RX_IN=1 → P_DATA=0x00 and data_valid=0 on the cycle after reset.
- No parity: PAR_EN=0, Prescale=8, frame 0x45 (start, bits 1,0,1,0,0,0,1,0, stop) → at end of stop bit P_DATA=0x45, data_valid=1.
- Odd parity: PAR_EN=1, PAR_TYP=1, Prescale=8, data 0xFF, parity bit 1 → P_DATA=0xFF, data_valid=1.
- Even parity: PAR_EN=1, PAR_TYP=0, Prescale=8, data 0xA8, parity bit 1 → P_DATA=0xA8, data_valid=1. The same frame with parity bit 0 → data_valid=0 and P_DATA unchanged.
- Framing error and glitch: 0x3C frame with stop bit 0 → data_valid=0 and P_DATA unchanged. RX_IN low for only 2 clocks at Prescale=8 → no frame started and outputs unchanged.
- Prescale=16 and 32 plus back-to-back: frames 0x5A then 0xC3, with a 1-cycle idle gap → data_valid=1 with P_DATA=0x5A after the first frame. data_valid drops at the second start bit, then data_valid=1 with P_DATA=0xC3.
